// File: rtl/countdown_24_pkg.sv
// Shared constants and types for the cascaded countdown timer (countdown_24).
// The optional auto-reload behaviour is enabled by defining COUNTDOWN_AUTO_RELOAD_EN.
package countdown_24_pkg;

  localparam int CD_W          = 24;
  localparam int CD_SLICE_W    = 8;
  localparam int CD_NUM_SLICES = CD_W / CD_SLICE_W;

  // Per-cycle action decided by the top-level control logic.
  typedef enum logic [2:0] {
    ACT_HOLD   = 3'd0,
    ACT_LOAD   = 3'd1,
    ACT_DEC    = 3'd2,
    ACT_TERM   = 3'd3,
    ACT_RELOAD = 3'd4,
    ACT_SAT    = 3'd5
  } cd_action_e;

  // An action that ends a count period raises the terminal-count pulse.
  function automatic logic is_terminal(input cd_action_e act);
    logic hit;
    case (act)
      ACT_TERM, ACT_RELOAD: hit = 1'b1;
      default:              hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/countdown_24_down_slice.sv
// One SLICE_W-bit down-counting slice with synchronous load and borrow-qualified decrement.
// A slice decrementing from zero wraps to all-ones; saturation is handled by the parent.
module down_slice
  import countdown_24_pkg::*;
#(
  parameter int SLICE_W = CD_SLICE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [SLICE_W-1:0] load_val,
  input  logic               dec_in,
  output logic [SLICE_W-1:0] cnt,
  output logic               is_zero
);

  localparam logic [SLICE_W-1:0] ONE  = {{(SLICE_W-1){1'b0}}, 1'b1};
  localparam logic [SLICE_W-1:0] ZERO = {SLICE_W{1'b0}};

  logic [SLICE_W-1:0] cnt_r;

  // Slice count register: reset, load, decrement or hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= ZERO;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec_in) begin
      cnt_r <= cnt_r - ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt     = cnt_r;
  assign is_zero = (cnt_r == ZERO);

endmodule

// File: rtl/countdown_24.sv
// Loadable cascaded down-counter: W bits from W/SLICE_W borrow-chained down_slice instances.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the last loaded value on terminal count.
module countdown_24
  import countdown_24_pkg::*;
#(
  parameter int W       = CD_W,
  parameter int SLICE_W = CD_SLICE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         tc_pulse
);

  localparam int           NS   = W / SLICE_W;
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  logic [W-1:0]  count_s;
  logic [W-1:0]  reload_r;
  logic [W-1:0]  slice_load_val_s;
  logic          slice_load_s;
  logic          count_en_s;
  logic [NS-1:0] slice_zero_s;
  logic [NS-1:0] slice_dec_s;
  logic          all_zero_s;
  logic          is_one_s;
  logic          reload_nz_s;
  logic          zero_next_s;
  logic          tc_next_s;
  logic          zero_r;
  logic          tc_r;
  cd_action_e    action_s;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // Reload register remembers the most recently loaded start value.
  always_ff @(posedge clk) begin
    if (reset) begin
      reload_r <= ZERO;
    end else if (load) begin
      reload_r <= load_val;
    end else begin
      reload_r <= reload_r;
    end
  end
`else
  assign reload_r = ZERO;
`endif

  assign all_zero_s  = &slice_zero_s;
  assign is_one_s    = (count_s == ONE);
  assign reload_nz_s = (reload_r != ZERO);

  // Decide this cycle's action; load beats en, and zero never underflows.
  always_comb begin
    action_s = ACT_HOLD;
    if (load) begin
      action_s = ACT_LOAD;
    end else if (!en) begin
      action_s = ACT_HOLD;
    end else if (all_zero_s) begin
      action_s = ACT_SAT;
    end else if (is_one_s && reload_nz_s) begin
      action_s = ACT_RELOAD;
    end else if (is_one_s) begin
      action_s = ACT_TERM;
    end else begin
      action_s = ACT_DEC;
    end
  end

  // Translate the action into slice load/decrement controls.
  always_comb begin
    slice_load_s     = 1'b0;
    slice_load_val_s = load_val;
    count_en_s       = 1'b0;
    case (action_s)
      ACT_LOAD: begin
        slice_load_s     = 1'b1;
        slice_load_val_s = load_val;
      end
      ACT_RELOAD: begin
        slice_load_s     = 1'b1;
        slice_load_val_s = reload_r;
      end
      ACT_DEC, ACT_TERM: begin
        count_en_s = 1'b1;
      end
      default: begin
        count_en_s = 1'b0;
      end
    endcase
  end

  // Next values of the zero flag and terminal-count pulse.
  always_comb begin
    zero_next_s = zero_r;
    tc_next_s   = is_terminal(action_s);
    case (action_s)
      ACT_LOAD:   zero_next_s = (load_val == ZERO);
      ACT_RELOAD: zero_next_s = 1'b0;
      ACT_TERM:   zero_next_s = 1'b1;
      ACT_SAT:    zero_next_s = 1'b1;
      ACT_DEC:    zero_next_s = 1'b0;
      default:    zero_next_s = zero_r;
    endcase
  end

  // Status flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_r <= 1'b1;
      tc_r   <= 1'b0;
    end else begin
      zero_r <= zero_next_s;
      tc_r   <= tc_next_s;
    end
  end

  assign slice_dec_s[0] = count_en_s;

  genvar k;
  generate
    // Slice k borrows only when every lower slice currently reads zero.
    for (k = 1; k < NS; k++) begin : g_borrow
      assign slice_dec_s[k] = slice_dec_s[k-1] & slice_zero_s[k-1];
    end

    for (k = 0; k < NS; k++) begin : g_slice
      down_slice #(
        .SLICE_W(SLICE_W)
      ) u_slice (
        .clk     (clk),
        .reset   (reset),
        .load    (slice_load_s),
        .load_val(slice_load_val_s[k*SLICE_W +: SLICE_W]),
        .dec_in  (slice_dec_s[k]),
        .cnt     (count_s[k*SLICE_W +: SLICE_W]),
        .is_zero (slice_zero_s[k])
      );
    end
  endgenerate

  assign count    = count_s;
  assign zero     = zero_r;
  assign tc_pulse = tc_r;

endmodule

// File: tb/tb_countdown_24.sv
// Directed self-checking bench for countdown_24; expectations follow COUNTDOWN_AUTO_RELOAD_EN.
`timescale 1ns/1ps
module tb_countdown_24;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        en;
  logic        load;
  logic [23:0] load_val;
  logic [23:0] count;
  logic        zero;
  logic        tc_pulse;

  int n_total;
  int n_bad;

  countdown_24 dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .zero    (zero),
    .tc_pulse(tc_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [23:0] c, input logic z, input logic t);
    check_val({tag, "_count"}, {8'h00, count}, {8'h00, c});
    check_val({tag, "_zero"}, {31'd0, zero}, {31'd0, z});
    check_val({tag, "_tc"}, {31'd0, tc_pulse}, {31'd0, t});
  endtask

  task automatic do_load(input logic [23:0] v);
    load = 1'b1; load_val = v; en = 1'b0;
    tick();
    load = 1'b0;
  endtask

  logic [23:0] m;
  logic        mtc;

  initial begin
    n_total = 0; n_bad = 0;
    reset = 1'b1; en = 1'b0; load = 1'b0; load_val = 24'h0;
    tick(); tick();
    reset = 1'b0;
    chk_state("rst_init", 24'h0, 1'b1, 1'b0);

    // Reset in the middle of counting.
    do_load(24'h000010);
    en = 1'b1;
    tick(); tick();
    chk_state("pre_rst", 24'h00000E, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chk_state("mid_rst1", 24'h0, 1'b1, 1'b0);
    tick();
    chk_state("mid_rst2", 24'h0, 1'b1, 1'b0);
    reset = 1'b0; en = 1'b0;
    tick();
    chk_state("post_rst", 24'h0, 1'b1, 1'b0);

    // Basic countdown from 5.
    do_load(24'h000005);
    chk_state("ld5", 24'h5, 1'b0, 1'b0);
    en = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      tick();
      chk_state("dn", 24'(i), 1'b0, 1'b0);
    end
    tick();
    if (AUTO) chk_state("term", 24'h5, 1'b0, 1'b1);
    else      chk_state("term", 24'h0, 1'b1, 1'b1);
    tick();
    if (AUTO) chk_state("after", 24'h4, 1'b0, 1'b0);
    else      chk_state("after", 24'h0, 1'b1, 1'b0);
    en = 1'b0;

    // Borrow across slices.
    do_load(24'h010000);
    en = 1'b1; tick(); en = 1'b0;
    chk_state("brw16", 24'h00FFFF, 1'b0, 1'b0);
    do_load(24'h000100);
    en = 1'b1; tick(); en = 1'b0;
    chk_state("brw8", 24'h0000FF, 1'b0, 1'b0);

    // Enable toggling 1,0,1 from 2.
    do_load(24'h000002);
    chk_state("tg0", 24'h2, 1'b0, 1'b0);
    en = 1'b1; tick();
    chk_state("tg1", 24'h1, 1'b0, 1'b0);
    en = 1'b0; tick();
    chk_state("tg2", 24'h1, 1'b0, 1'b0);
    en = 1'b1; tick();
    if (AUTO) chk_state("tg3", 24'h2, 1'b0, 1'b1);
    else      chk_state("tg3", 24'h0, 1'b1, 1'b1);
    en = 1'b0; tick();
    check_val("tg4_tc", {31'd0, tc_pulse}, 32'd0);

    // Load beats a 1->0 transition.
    do_load(24'h000002);
    en = 1'b1; tick();
    chk_state("lp_one", 24'h1, 1'b0, 1'b0);
    load = 1'b1; load_val = 24'h000003; en = 1'b1;
    tick();
    chk_state("lp3", 24'h3, 1'b0, 1'b0);
    load_val = 24'h0;
    tick();
    chk_state("lp0", 24'h0, 1'b1, 1'b0);
    load = 1'b0;

    // Saturation at zero.
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_state("sat", 24'h0, 1'b1, 1'b0);
    end
    en = 1'b0;

    // Periodic behaviour from 4 (reload when enabled, stop at 0 otherwise).
    do_load(24'h000004);
    chk_state("pr_ld", 24'h4, 1'b0, 1'b0);
    m = 24'h4;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mtc = 1'b0;
      if (m == 24'h1) begin
        m = AUTO ? 24'h4 : 24'h0;
        mtc = 1'b1;
      end else if (m != 24'h0) begin
        m = m - 24'h1;
      end
      tick();
      chk_state("per", m, (m == 24'h0), mtc);
    end
    en = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
